// File: rtl/axis_pkg.sv
//------------------------------------------------------------------------------
// axis_pkg : shared AXI-Stream error bit indices and monitor FSM state type.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package axis_pkg;

   localparam int c_err_w             = 6;
   localparam int c_err_valid_drop    = 0;
   localparam int c_err_data_chg      = 1;
   localparam int c_err_last_chg      = 2;
   localparam int c_err_stall_timeout = 3;
   localparam int c_err_pkt_overlen   = 4;
   localparam int c_err_last_no_valid = 5;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_IN_PKT = 1'b1
   } axis_state_e;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
//------------------------------------------------------------------------------
// sat_counter : up-counter that sticks at all-ones, with synchronous clear.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != {WIDTH{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/axis_protocol_monitor.sv
//------------------------------------------------------------------------------
// axis_protocol_monitor : passive AXI-Stream checker with sticky error flags,
//                         beat/packet statistics and backpressure tracking.
// Revision              : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axis_protocol_monitor
   import axis_pkg::*;
#(
   parameter int DATA_W        = 64,
   parameter int STALL_LIMIT   = 100,
   parameter int MAX_PKT_BEATS = 256,
   parameter int CNT_W         = 32,
   parameter bit STRICT_LAST   = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DATA_W-1:0]  tdata,
   input  logic               tvalid,
   input  logic               tready,
   input  logic               tlast,
   input  logic               clr,
   output logic [5:0]         err_flags,
   output logic               err_pulse,
   output logic [CNT_W-1:0]   beat_cnt,
   output logic [CNT_W-1:0]   pkt_cnt,
   output logic [15:0]        stall_max,
   output logic               in_pkt
);

   // One spare code above MAX_PKT_BEATS so the in-packet count saturates past the limit.
   localparam int c_pkt_w = $clog2(MAX_PKT_BEATS + 2);

   logic                 w_hs;
   logic                 w_stall;
   logic                 r_pend;
   logic [DATA_W-1:0]    r_cap_data;
   logic                 r_cap_last;
   logic [15:0]          w_stall_cnt;
   logic [15:0]          w_stall_nxt;
   logic [15:0]          r_stall_max;
   logic [c_pkt_w-1:0]   r_pkt_beats;
   logic                 w_last_no_valid;
   logic [c_err_w-1:0]   w_new;
   logic [c_err_w-1:0]   r_flags;
   logic                 r_pulse;
   axis_state_e          r_state;
   axis_state_e          w_state_nxt;

   assign w_hs    = tvalid && tready;
   assign w_stall = tvalid && !tready;

   // Pending holds the last stalled beat; any non-stall edge releases it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend     <= 1'b0;
         r_cap_data <= '0;
         r_cap_last <= 1'b0;
      end else if (w_stall) begin
         r_pend     <= 1'b1;
         r_cap_data <= tdata;
         r_cap_last <= tlast;
      end else begin
         r_pend     <= 1'b0;
      end
   end

   sat_counter #(.WIDTH(16)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (!w_stall),
      .i_inc (w_stall),
      .o_cnt (w_stall_cnt)
   );

   assign w_stall_nxt = (w_stall_cnt == 16'hFFFF) ? w_stall_cnt : w_stall_cnt + 16'd1;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_stall_max <= '0;
      end else if (w_stall && (w_stall_nxt > r_stall_max)) begin
         r_stall_max <= w_stall_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pkt_beats <= '0;
      end else if (w_hs) begin
         if (tlast) begin
            r_pkt_beats <= '0;
         end else if (32'(r_pkt_beats) <= MAX_PKT_BEATS) begin
            r_pkt_beats <= r_pkt_beats + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_hs && !tlast) w_state_nxt = ST_IN_PKT;
         ST_IN_PKT: if (w_hs && tlast)  w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_pkt = (r_state == ST_IN_PKT);
   end

   generate
      if (STRICT_LAST) begin : g_strict_last
         assign w_last_no_valid = tlast && !tvalid;
      end else begin : g_lax_last
         assign w_last_no_valid = 1'b0;
      end
   endgenerate

   // Data/last stability is only meaningful while the source still asserts valid.
   always_comb begin
      w_new                      = '0;
      w_new[c_err_valid_drop]    = r_pend && !tvalid;
      w_new[c_err_data_chg]      = r_pend && tvalid && (tdata != r_cap_data);
      w_new[c_err_last_chg]      = r_pend && tvalid && (tlast != r_cap_last);
      w_new[c_err_stall_timeout] = w_stall && (32'(w_stall_nxt) == STALL_LIMIT);
      w_new[c_err_pkt_overlen]   = w_hs && (32'(r_pkt_beats) >= MAX_PKT_BEATS);
      w_new[c_err_last_no_valid] = w_last_no_valid;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_flags <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_flags <= r_flags | w_new;
         r_pulse <= |(w_new & ~r_flags);
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_beat_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (clr),
      .i_inc (w_hs),
      .o_cnt (beat_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_pkt_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (clr),
      .i_inc (w_hs && tlast),
      .o_cnt (pkt_cnt)
   );

   assign err_flags = r_flags;
   assign err_pulse = r_pulse;
   assign stall_max = r_stall_max;

endmodule

`default_nettype wire

// File: tb/tb_axis_protocol_monitor.sv
//------------------------------------------------------------------------------
// tb_axis_protocol_monitor : directed self-checking bench for the AXIS monitor.
// Revision                 : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_axis_protocol_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] tdata = '0;
   logic        tvalid = 1'b0;
   logic        tready = 1'b0;
   logic        tlast = 1'b0;
   logic        clr = 1'b0;
   logic [5:0]  err_flags;
   logic        err_pulse;
   logic [31:0] beat_cnt;
   logic [31:0] pkt_cnt;
   logic [15:0] stall_max;
   logic        in_pkt;

   int n_checks = 0;
   int n_errors = 0;

   axis_protocol_monitor #(
      .DATA_W        (64),
      .STALL_LIMIT   (100),
      .MAX_PKT_BEATS (4),
      .CNT_W         (32),
      .STRICT_LAST   (1'b1)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .tdata     (tdata),
      .tvalid    (tvalid),
      .tready    (tready),
      .tlast     (tlast),
      .clr       (clr),
      .err_flags (err_flags),
      .err_pulse (err_pulse),
      .beat_cnt  (beat_cnt),
      .pkt_cnt   (pkt_cnt),
      .stall_max (stall_max),
      .in_pkt    (in_pkt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic r, input logic l, input logic [63:0] d);
      tvalid = v;
      tready = r;
      tlast  = l;
      tdata  = d;
   endtask

   task automatic idle_clr();
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      // Reset
      tick();
      tick();
      rst = 1'b0;
      check("rst_flags", 64'(err_flags), 64'h0);
      check("rst_pulse", 64'(err_pulse), 64'h0);
      check("rst_beat", 64'(beat_cnt), 64'h0);
      check("rst_pkt", 64'(pkt_cnt), 64'h0);
      check("rst_smax", 64'(stall_max), 64'h0);
      check("rst_inpkt", 64'(in_pkt), 64'h0);

      // 3-beat packet, no backpressure
      drive(1'b1, 1'b1, 1'b0, 64'h11); tick();
      check("p3_inpkt_open", 64'(in_pkt), 64'h1);
      drive(1'b1, 1'b1, 1'b0, 64'h22); tick();
      drive(1'b1, 1'b1, 1'b1, 64'h33); tick();
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      check("p3_beat", 64'(beat_cnt), 64'd3);
      check("p3_pkt", 64'(pkt_cnt), 64'd1);
      check("p3_flags", 64'(err_flags), 64'h0);
      check("p3_inpkt_close", 64'(in_pkt), 64'h0);

      // Data change while stalled
      drive(1'b1, 1'b0, 1'b1, 64'hAA); tick(); tick();
      tdata = 64'hBB; tick();
      check("dchg_flags", 64'(err_flags), 64'h02);
      check("dchg_pulse", 64'(err_pulse), 64'h1);
      tick();
      check("dchg_pulse_once", 64'(err_pulse), 64'h0);
      check("dchg_smax", 64'(stall_max), 64'd4);
      tready = 1'b1; tick();
      check("dchg_beat", 64'(beat_cnt), 64'd4);
      check("dchg_pkt", 64'(pkt_cnt), 64'd2);
      idle_clr();
      check("clr_flags", 64'(err_flags), 64'h0);
      check("clr_beat", 64'(beat_cnt), 64'h0);
      check("clr_smax", 64'(stall_max), 64'h0);

      // Stall timeout at STALL_LIMIT
      drive(1'b1, 1'b0, 1'b1, 64'h5);
      repeat (99) tick();
      check("to_flags_99", 64'(err_flags), 64'h0);
      check("to_smax_99", 64'(stall_max), 64'd99);
      tick();
      check("to_flags_100", 64'(err_flags), 64'h08);
      check("to_pulse", 64'(err_pulse), 64'h1);
      check("to_smax_100", 64'(stall_max), 64'd100);
      tready = 1'b1; tick();
      check("to_smax_hold", 64'(stall_max), 64'd100);
      idle_clr();

      // Over-length packet with MAX_PKT_BEATS=4
      drive(1'b1, 1'b1, 1'b0, 64'h9);
      repeat (4) tick();
      check("ovl_flags_4", 64'(err_flags), 64'h0);
      tick();
      check("ovl_flags_5", 64'(err_flags), 64'h10);
      check("ovl_pulse", 64'(err_pulse), 64'h1);
      check("ovl_beat", 64'(beat_cnt), 64'd5);
      check("ovl_inpkt", 64'(in_pkt), 64'h1);
      tlast = 1'b1; tick();
      check("ovl_close_inpkt", 64'(in_pkt), 64'h0);
      check("ovl_close_pkt", 64'(pkt_cnt), 64'd1);
      idle_clr();

      // clr coincident with the tlast handshake
      drive(1'b1, 1'b1, 1'b0, 64'h1); tick();
      check("clrl_inpkt_open", 64'(in_pkt), 64'h1);
      drive(1'b1, 1'b1, 1'b1, 64'h2);
      clr = 1'b1; tick();
      clr = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      check("clrl_pkt", 64'(pkt_cnt), 64'd0);
      check("clrl_beat", 64'(beat_cnt), 64'd0);
      check("clrl_inpkt", 64'(in_pkt), 64'h0);

      // Reset mid-packet
      drive(1'b1, 1'b1, 1'b0, 64'h3); tick(); tick();
      check("rmid_beat", 64'(beat_cnt), 64'd2);
      check("rmid_inpkt", 64'(in_pkt), 64'h1);
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      rst = 1'b1; tick();
      rst = 1'b0;
      check("rmid_beat0", 64'(beat_cnt), 64'd0);
      check("rmid_pkt0", 64'(pkt_cnt), 64'd0);
      check("rmid_inpkt0", 64'(in_pkt), 64'h0);
      drive(1'b1, 1'b1, 1'b1, 64'h4); tick();
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      check("rmid_1b_pkt", 64'(pkt_cnt), 64'd1);
      check("rmid_1b_beat", 64'(beat_cnt), 64'd1);
      check("rmid_1b_inpkt", 64'(in_pkt), 64'h0);
      check("rmid_1b_flags", 64'(err_flags), 64'h0);

      // Valid drop, then tlast without tvalid
      drive(1'b1, 1'b0, 1'b0, 64'h7); tick();
      tvalid = 1'b0; tick();
      check("vdrop_flags", 64'(err_flags), 64'h01);
      tlast = 1'b1; tick();
      check("lnv_flags", 64'(err_flags), 64'h21);
      check("lnv_pulse", 64'(err_pulse), 64'h1);
      idle_clr();

      // Last change while stalled
      drive(1'b1, 1'b0, 1'b0, 64'h8); tick();
      tlast = 1'b1; tick();
      check("lchg_flags", 64'(err_flags), 64'h04);
      tready = 1'b1; tick();
      drive(1'b0, 1'b0, 1'b0, 64'h0); tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
